// File: rtl/bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter (double dabble), one shift step per clock.
// Results saturate to 9999 with overflow set for operands above 9999.
module bcd_seq_ctrl #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] binary,
  output logic         busy,
  output logic         done,
  output logic [3:0]   uni,
  output logic [3:0]   dec,
  output logic [3:0]   cen,
  output logic [3:0]   mil,
  output logic         overflow,
  output logic [1:0]   fsm_state
);

  // Handshake: start is a level sampled each rising edge; it is taken only
  // in IDLE (busy=0, done=0). done pulses for one cycle when results update.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int CW = $clog2(N + 1);

  state_t         state;
  logic [N-1:0]   operand;
  logic [15:0]    scratch;
  logic [CW-1:0]  cnt;
  logic           ovf_pending;
  logic [15:0]    adj;
  logic [15:0]    scratch_nxt;

  // One double-dabble step: correct digits >= 5, then shift in the next operand bit.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < 4; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    scratch_nxt = {adj[14:0], operand[N-1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      operand     <= '0;
      scratch     <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      uni         <= '0;
      dec         <= '0;
      cen         <= '0;
      mil         <= '0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            operand     <= binary;
            scratch     <= '0;
            cnt         <= '0;
            ovf_pending <= (32'(binary) > 32'd9999);
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= scratch_nxt;
          operand <= {operand[N-2:0], 1'b0};
          cnt     <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            state    <= DONE;
            overflow <= ovf_pending;
            {mil, cen, dec, uni} <= ovf_pending ? 16'h9999 : scratch_nxt;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == SHIFT);
  assign done      = (state == DONE);
  assign fsm_state = state;

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Randomized bench for bcd_seq_ctrl at N=10 and N=14 against a decimal-arithmetic model.
module tb_bcd_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start_a, start_b;
  logic [9:0]  bin_a;
  logic [13:0] bin_b;
  logic        busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;
  logic [3:0]  uni_a, dec_a, cen_a, mil_a, uni_b, dec_b, cen_b, mil_b;
  logic [1:0]  st_a, st_b;

  int          n_checks;
  int          n_pass;
  int          dut_sel;
  logic [16:0] exp_q[$];
  logic        busy_s, done_s;
  logic [16:0] res_s;

  bcd_seq_ctrl #(.N(10)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .binary(bin_a),
    .busy(busy_a), .done(done_a), .uni(uni_a), .dec(dec_a), .cen(cen_a), .mil(mil_a),
    .overflow(ovf_a), .fsm_state(st_a)
  );

  bcd_seq_ctrl #(.N(14)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .binary(bin_b),
    .busy(busy_b), .done(done_b), .uni(uni_b), .dec(dec_b), .cen(cen_b), .mil(mil_b),
    .overflow(ovf_b), .fsm_state(st_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    busy_s = busy_a;
    done_s = done_a;
    res_s  = {ovf_a, mil_a, cen_a, dec_a, uni_a};
    if (dut_sel == 1) begin
      busy_s = busy_b;
      done_s = done_b;
      res_s  = {ovf_b, mil_b, cen_b, dec_b, uni_b};
    end
  end

  // reference: {overflow, thousands, hundreds, tens, units}
  function automatic logic [16:0] model(input int x);
    logic [16:0] r;
    if (x > 9999) begin
      r = {1'b1, 4'd9, 4'd9, 4'd9, 4'd9};
    end else begin
      r = {1'b0, 4'((x / 1000) % 10), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic drive(input int sel, input logic s, input int x);
    if (sel == 0) begin
      start_a = s;
      bin_a   = x[9:0];
    end else begin
      start_b = s;
      bin_b   = x[13:0];
    end
  endtask

  // Full conversion: timing of busy/done, result at done, result held afterwards.
  task automatic convert(input int sel, input int x);
    int          n;
    int          busy_cnt;
    int          done_at;
    int          done_cnt;
    logic [16:0] exp;
    n = (sel == 1) ? 14 : 10;
    dut_sel = sel;
    exp = model(x);
    exp_q.push_back(exp);
    @(negedge clk);
    drive(sel, 1'b1, x);
    @(negedge clk);
    drive(sel, 1'b0, int'($urandom));
    busy_cnt = 0;
    done_at  = -1;
    done_cnt = 0;
    for (int i = 0; i < n + 2; i++) begin
      if (busy_s) busy_cnt++;
      if (done_s) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
        if (exp_q.size() > 0) check($sformatf("result x=%0d", x), 32'(res_s), 32'(exp_q.pop_front()));
      end
      @(negedge clk);
    end
    check("busy_cycles", busy_cnt, n);
    check("done_edge", done_at, n);
    check("done_pulses", done_cnt, 1);
    check("result_hold", 32'(res_s), 32'(exp));
    exp_q.delete();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    dut_sel  = 0;
    rst      = 1'b0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    bin_a    = '0;
    bin_b    = '0;

    #2 rst = 1'b1;
    #1;
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_res_a", 32'(res_s), 32'd0);
    dut_sel = 1;
    #1;
    check("rst_res_b", 32'(res_s), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    convert(0, 1023);
    convert(0, 0);
    convert(0, 999);
    convert(1, 12345);
    convert(1, 9999);
    convert(1, 0);
    convert(1, 16383);
    convert(1, 10000);

    // start held high across busy and done: one result, then immediate re-accept
    begin
      int done_cnt;
      dut_sel = 0;
      done_cnt = 0;
      @(negedge clk);
      drive(0, 1'b1, 500);
      @(negedge clk);
      bin_a = 10'd7;
      for (int i = 0; i < 12; i++) begin
        if (done_s) begin
          done_cnt++;
          check("held_result_500", 32'(res_s), 32'(model(500)));
        end
        if (i == 11) check("ignored_in_done", busy_s, 1'b0);
        @(negedge clk);
      end
      check("held_done_pulses", done_cnt, 1);
      check("accept_after_done", busy_s, 1'b1);
      start_a = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 12; i++) begin
        if (done_s) begin
          done_cnt++;
          check("held_result_7", 32'(res_s), 32'(model(7)));
        end
        @(negedge clk);
      end
      check("second_done_pulses", done_cnt, 1);
    end

    // asynchronous reset in the middle of a conversion
    begin
      int seen;
      dut_sel = 0;
      @(negedge clk);
      drive(0, 1'b1, 1000);
      @(negedge clk);
      start_a = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_busy", busy_s, 1'b0);
      check("abort_done", done_s, 1'b0);
      check("abort_res", 32'(res_s), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
        if (done_s || busy_s) seen++;
        @(negedge clk);
      end
      check("abort_no_activity", seen, 0);
      convert(0, 42);
    end

    // binary held at a different value while busy must not disturb the result
    for (int i = 0; i < 20; i++) convert(0, int'($urandom_range(0, 1023)));
    for (int i = 0; i < 20; i++) convert(1, int'($urandom_range(0, 16383)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_seq_ctrl.md
BCD_SEQ_CTRL -- requirements
Module: bcd_seq_ctrl

Interface
REQ-001 Parameter N, default 10: width of the binary operand; legal range 4..14.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  conversion request, sampled on the rising edge of clk.
REQ-005 binary  input  N  unsigned operand, sampled only on the edge that accepts start.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  one-cycle pulse; the result is valid when it rises.
REQ-008 uni, dec, cen, mil  output  4 each  BCD units, tens, hundreds and thousands digits, each registered.
REQ-009 overflow  output  1  high when the last accepted operand was greater than 9999, registered.

Function
REQ-010 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-011 IDLE -> SHIFT when start=1 is sampled in IDLE; on that edge, load operand=binary, clear the 16-bit BCD scratch, clear the step counter, and latch ovf_pending=(binary>9999).
REQ-012 SHIFT SHALL run exactly N double-dabble steps, one per edge.
- Per step: each scratch digit >=5 gets +3; then {scratch, operand} shifts left by 1; counter increments.
REQ-013 SHIFT -> DONE on the edge that performs step N.
- On that same edge, uni/dec/cen/mil load from the scratch digits with the final step applied.
- On that same edge, overflow loads ovf_pending.
REQ-014 If ovf_pending=1, uni/dec/cen/mil SHALL load 9,9,9,9 instead of the scratch value.
REQ-015 DONE -> IDLE unconditionally on the next edge.
REQ-016 busy SHALL equal (state==SHIFT); done SHALL equal (state==DONE).
- Both are registered-state decodes with no combinational path from start.
REQ-017 Latency: start accepted at edge k -> busy high from edge k to edge k+N -> done high from edge k+N to edge k+N+1.
REQ-018 start SHALL be ignored in SHIFT and in DONE.
- There is no queuing; a new request is accepted only when sampled in IDLE.
- Minimum start-to-start spacing is therefore N+2 cycles.
REQ-019 binary changes after the accepting edge SHALL NOT affect the conversion in progress.
REQ-020 uni, dec, cen, mil and overflow SHALL hold their values between done pulses and change only on the edge entering DONE.
REQ-021 Scratch arithmetic SHALL be 16 bits wide (4 digits); each digit SHALL stay within 0..9 at every step for operands <=9999.
REQ-022 Operand 0 SHALL still take the full N steps and produce 0,0,0,0.

Reset
REQ-023 While rst=1, the block SHALL asynchronously force the following, regardless of clk:
- state=IDLE, busy=0, done=0;
- uni=dec=cen=mil=0, overflow=0;
- counter, scratch and operand cleared.
REQ-024 Asserting rst mid-conversion SHALL abort it with no done pulse.
REQ-025 After rst deasserts, the first start sampled in IDLE SHALL be accepted normally.

Verification
REQ-026 N=10, binary=1023, start pulse at edge k -> busy high for 10 cycles, done pulse at edge k+10; mil,cen,dec,uni = 1,0,2,3; overflow=0.
REQ-027 N=10, binary=0 -> done at edge k+10; digits 0,0,0,0. Then binary=999 -> digits 0,9,9,9.
REQ-028 N=10, binary=500 accepted; start=1 with binary=7 held through the busy and done cycles -> exactly one done pulse for 500 (digits 0,5,0,0); the request for 7 is accepted on the first IDLE edge after DONE.
REQ-029 N=14, binary=12345 -> done at edge k+14; digits 9,9,9,9; overflow=1. Then binary=9999 -> digits 9,9,9,9 with overflow=0.
REQ-030 N=10, binary=1000 accepted; rst pulsed during step 5 -> busy=0, done never pulses, digits all 0. A new start with 42 afterwards -> digits 0,0,4,2 after 10 cycles.
REQ-031 Random operands 0..(2^N)-1 for N=10 and N=14 -> each digit SHALL match (x/10^i)%10, saturated to 9999 with overflow=1 when x>9999.
